// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data cache memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbGntI = 2'd1,
        ArbGntD = 2'd2
    } arb_state_e;

    typedef enum logic {
        GrantI = 1'b0,
        GrantD = 1'b1
    } grant_e;

    localparam logic RstEnable = 1'b0;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter in front of a single memory port.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default lets dcache win ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_req_i,
    input  logic [31:0] icache_addr_i,
    output logic        icache_rep_o,
    output logic [63:0] icache_rep_data_o,
    input  logic        dcache_req_i,
    input  logic [31:0] dcache_addr_i,
    input  logic        dcache_write_i,
    input  logic [63:0] dcache_write_data_i,
    input  logic [7:0]  dcache_write_mask_i,
    output logic        dcache_rep_o,
    output logic [63:0] dcache_rep_data_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_write_o,
    output logic [63:0] mem_write_data_o,
    output logic [7:0]  mem_write_mask_o,
    input  logic        mem_rep_i,
    input  logic [63:0] mem_rep_data_i
);

    arb_state_e state_q, state_d;
    logic       tie_to_d;
    logic       pick_d;
    logic       grant_now;

    assign grant_now = (state_q == ArbIdle) && (icache_req_i || dcache_req_i);

`ifdef ARB_ROUND_ROBIN_EN
    grant_e last_grant_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            last_grant_q <= GrantI;
        else if (grant_now)
            last_grant_q <= pick_d ? GrantD : GrantI;
    end

    // A tie goes to whoever was not served last.
    assign tie_to_d = (last_grant_q == GrantI);
`else
    assign tie_to_d = 1'b1;
`endif

    assign pick_d = dcache_req_i && (!icache_req_i || tie_to_d);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ArbIdle: if (grant_now) state_d = pick_d ? ArbGntD : ArbGntI;
            ArbGntI,
            ArbGntD: if (mem_rep_i) state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q          <= ArbIdle;
            mem_addr_o       <= '0;
            mem_write_o      <= 1'b0;
            mem_write_data_o <= '0;
            mem_write_mask_o <= '0;
        end else begin
            state_q <= state_d;
            // Payload is captured only at grant, so it holds for the whole transaction.
            if (grant_now) begin
                if (pick_d) begin
                    mem_addr_o       <= dcache_addr_i;
                    mem_write_o      <= dcache_write_i;
                    mem_write_data_o <= dcache_write_data_i;
                    mem_write_mask_o <= dcache_write_mask_i;
                end else begin
                    mem_addr_o       <= icache_addr_i;
                    mem_write_o      <= 1'b0;
                    mem_write_data_o <= '0;
                    mem_write_mask_o <= '0;
                end
            end
        end
    end

    assign mem_req_o         = (state_q != ArbIdle);
    assign icache_rep_o      = mem_rep_i && (state_q == ArbGntI);
    assign dcache_rep_o      = mem_rep_i && (state_q == ArbGntD);
    assign icache_rep_data_o = mem_rep_data_i;
    assign dcache_rep_data_o = mem_rep_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, expected grants queued in order.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_req_i;
    logic [31:0] icache_addr_i;
    logic        icache_rep_o;
    logic [63:0] icache_rep_data_o;
    logic        dcache_req_i;
    logic [31:0] dcache_addr_i;
    logic        dcache_write_i;
    logic [63:0] dcache_write_data_i;
    logic [7:0]  dcache_write_mask_i;
    logic        dcache_rep_o;
    logic [63:0] dcache_rep_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_write_o;
    logic [63:0] mem_write_data_o;
    logic [7:0]  mem_write_mask_o;
    logic        mem_rep_i;
    logic [63:0] mem_rep_data_i;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_req_i(icache_req_i), .icache_addr_i(icache_addr_i),
        .icache_rep_o(icache_rep_o), .icache_rep_data_o(icache_rep_data_o),
        .dcache_req_i(dcache_req_i), .dcache_addr_i(dcache_addr_i),
        .dcache_write_i(dcache_write_i), .dcache_write_data_i(dcache_write_data_i),
        .dcache_write_mask_i(dcache_write_mask_i),
        .dcache_rep_o(dcache_rep_o), .dcache_rep_data_o(dcache_rep_data_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_write_o(mem_write_o),
        .mem_write_data_o(mem_write_data_o), .mem_write_mask_o(mem_write_mask_o),
        .mem_rep_i(mem_rep_i), .mem_rep_data_i(mem_rep_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        bit          wr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   mem_lat = 3;
    bit   rep_force = 1'b0;
    bit   zw_mode = 1'b0;
    int   last_rep_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 64'h1122334455667788 : {a ^ 32'hDEADBEEF, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_i(input logic [31:0] a);
        exp_t e;
        e.is_d = 1'b0; e.addr = a; e.wr = 1'b0; e.wdata = '0; e.mask = 8'h00;
        sb.push_back(e);
    endfunction

    function automatic void push_d(input logic [31:0] a, input bit wr,
                                   input logic [63:0] d, input logic [7:0] m);
        exp_t e;
        e.is_d = 1'b1; e.addr = a; e.wr = wr; e.wdata = d; e.mask = m;
        sb.push_back(e);
    endfunction

    // Memory model: reply mem_lat cycles into the grant (0 = first grant cycle).
    initial begin
        int g = 0;
        mem_rep_i = 1'b0;
        mem_rep_data_i = '0;
        forever begin
            @(posedge clk); #2;
            if (rep_force) begin
                mem_rep_i = 1'b1;
                mem_rep_data_i = 64'h0BAD_0BAD_0BAD_0BAD;
            end else if (mem_req_o) begin
                mem_rep_i = (g == mem_lat);
                mem_rep_data_i = mem_fn(mem_addr_o);
                g++;
            end else begin
                mem_rep_i = 1'b0;
                g = 0;
            end
        end
    end

    // Monitor: payload checked every grant cycle against the expected winner, popped on rep.
    initial begin
        bit   prev_rep = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_rep = 1'b0;
                continue;
            end
            if (prev_rep) chk("idle_after_rep", mem_req_o, 1'b0);
            prev_rep = icache_rep_o | dcache_rep_o;
            if (mem_req_o && sb.size() > 0) begin
                chk("grant_addr", mem_addr_o, sb[0].addr);
                chk("grant_write", mem_write_o, sb[0].wr);
                chk("grant_mask", mem_write_mask_o, sb[0].mask);
                if (sb[0].wr) chk("grant_wdata", mem_write_data_o, sb[0].wdata);
            end
            if (icache_rep_o || dcache_rep_o) begin
                chk("single_rep", icache_rep_o & dcache_rep_o, 1'b0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rep: got i=%b d=%b expected none (cycle %0d)",
                             icache_rep_o, dcache_rep_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rep_is_dcache", dcache_rep_o, e.is_d);
                    chk("rep_data", e.is_d ? dcache_rep_data_o : icache_rep_data_o, mem_fn(e.addr));
                    if (zw_mode && last_rep_cyc >= 0) chk("zero_wait_spacing", cyc - last_rep_cyc, 2);
                    last_rep_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_rep(input bit d);
        int n = 0;
        forever begin
            @(negedge clk);
            if (d ? dcache_rep_o : icache_rep_o) break;
            n++;
            if (n > 60) begin
                n_tests++;
                n_fail++;
                $display("FAIL rep_timeout: got no rep expected %s rep", d ? "dcache" : "icache");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic icache_txn(input logic [31:0] a);
        icache_addr_i = a;
        icache_req_i  = 1'b1;
        wait_rep(1'b0);
        icache_req_i  = 1'b0;
    endtask

    task automatic dcache_txn(input logic [31:0] a, input bit wr,
                              input logic [63:0] d, input logic [7:0] m);
        dcache_addr_i       = a;
        dcache_write_i      = wr;
        dcache_write_data_i = d;
        dcache_write_mask_i = m;
        dcache_req_i        = 1'b1;
        wait_rep(1'b1);
        dcache_req_i        = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b0;
        icache_req_i = 1'b0; icache_addr_i = '0;
        dcache_req_i = 1'b0; dcache_addr_i = '0; dcache_write_i = 1'b0;
        dcache_write_data_i = '0; dcache_write_mask_i = '0;

        // Reset state, with memory replying into IDLE
        step(2);
        rep_force = 1'b1;
        step(1);
        @(negedge clk);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_mem_wdata", mem_write_data_o, 64'h0);
        chk("rst_mem_mask", mem_write_mask_o, 8'h0);
        chk("rst_icache_rep", icache_rep_o, 1'b0);
        chk("rst_dcache_rep", dcache_rep_o, 1'b0);
        @(posedge clk); #1;
        rep_force = 1'b0;
        rst = 1'b1;
        step(2);

        // First tie after reset goes to dcache in both policies
        push_d(32'h400, 1'b1, 64'h0102030405060708, 8'hFF);
        push_i(32'h500);
        fork
            icache_txn(32'h500);
            dcache_txn(32'h400, 1'b1, 64'h0102030405060708, 8'hFF);
        join
        step(2);

        // Icache-only fill, memory replies after 3 cycles
        mem_lat = 3;
        push_i(32'h100);
        icache_txn(32'h100);
        step(2);

        // Dcache write-through
        push_d(32'h204, 1'b1, 64'hAABBCCDD_AABBCCDD, 8'hF0);
        dcache_txn(32'h204, 1'b1, 64'hAABBCCDD_AABBCCDD, 8'hF0);
        step(2);

        // Dcache line fill
        mem_lat = 1;
        push_d(32'h300, 1'b0, 64'h5555_6666_7777_8888, 8'h0F);
        dcache_txn(32'h300, 1'b0, 64'h5555_6666_7777_8888, 8'h0F);
        step(2);

        // Second tie, last grant was dcache: policy decides the winner
`ifdef ARB_ROUND_ROBIN_EN
        push_i(32'h540);
        push_d(32'h440, 1'b1, 64'hFEDC_BA98_7654_3210, 8'hFF);
`else
        push_d(32'h440, 1'b1, 64'hFEDC_BA98_7654_3210, 8'hFF);
        push_i(32'h540);
`endif
        fork
            icache_txn(32'h540);
            dcache_txn(32'h440, 1'b1, 64'hFEDC_BA98_7654_3210, 8'hFF);
        join
        step(2);

        // Zero-wait alternating traffic: one transaction every 2 cycles
        mem_lat = 0;
        zw_mode = 1'b1;
        last_rep_cyc = -1;
        push_i(32'h1000);
        push_d(32'h2000, 1'b1, 64'h1111_2222_3333_4444, 8'h3C);
        push_i(32'h1040);
        push_d(32'h2040, 1'b0, 64'h9999_AAAA_BBBB_CCCC, 8'hC3);
        push_i(32'h1080);
        fork
            begin
                icache_txn(32'h1000);
                step(1);
                icache_txn(32'h1040);
                step(1);
                icache_txn(32'h1080);
            end
            begin
                step(1);
                dcache_txn(32'h2000, 1'b1, 64'h1111_2222_3333_4444, 8'h3C);
                step(1);
                dcache_txn(32'h2040, 1'b0, 64'h9999_AAAA_BBBB_CCCC, 8'hC3);
            end
        join
        zw_mode = 1'b0;
        step(2);

        // Reset in the middle of a dcache grant, then a late memory reply
        mem_lat = 20;
        push_d(32'h600, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 8'h81);
        dcache_addr_i = 32'h600; dcache_write_i = 1'b1;
        dcache_write_data_i = 64'hCAFE_F00D_CAFE_F00D; dcache_write_mask_i = 8'h81;
        dcache_req_i = 1'b1;
        step(3);
        rst = 1'b0;
        dcache_req_i = 1'b0;
        step(1);
        rst = 1'b1;
        void'(sb.pop_front());
        step(2);
        rep_force = 1'b1;
        @(negedge clk);
        chk("late_rep_icache", icache_rep_o, 1'b0);
        chk("late_rep_dcache", dcache_rep_o, 1'b0);
        @(posedge clk); #1;
        rep_force = 1'b0;
        @(negedge clk);
        chk("after_rst_mem_req", mem_req_o, 1'b0);
        chk("after_rst_state", dut.state_q, ArbIdle);
        step(1);

        // Recovery after the abandoned transaction
        mem_lat = 1;
        push_d(32'h700, 1'b0, 64'h0, 8'h00);
        dcache_txn(32'h700, 1'b0, 64'h0, 8'h00);
        step(3);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
